// File: rtl/spi_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_loader
// Brief    : Oversampled SPI frame receiver; commits a full frame atomically
//            to the x/y matrix registers only when the bit count is exact.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_loader #(
    parameter int FRAME_BITS  = 144,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sck,
    input  logic                    sdi,
    input  logic                    load,
    output logic [FRAME_BITS/2-1:0] xMatrix,
    output logic [FRAME_BITS/2-1:0] yMatrix,
    output logic                    frame_valid,
    output logic                    done,
    output logic                    bit_err
);

    localparam int c_HALF  = FRAME_BITS / 2;
    localparam int c_CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FRAME_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_OVF  = c_CNT_W'(FRAME_BITS + 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SHIFT  = 3'd1;
    localparam logic [2:0] c_CHECK  = 3'd2;
    localparam logic [2:0] c_COMMIT = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic [SYNC_STAGES-1:0] r_load_sync;
    logic                   r_sck_prev;
    logic                   r_load_prev;
    logic [2:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [FRAME_BITS-1:0]  r_shadow;

    logic w_sck;
    logic w_sdi;
    logic w_load;
    logic w_sck_rise;
    logic w_load_rise;
    logic w_load_fall;

    assign w_sck       = r_sck_sync[SYNC_STAGES-1];
    assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];
    assign w_load      = r_load_sync[SYNC_STAGES-1];
    assign w_sck_rise  = w_sck & ~r_sck_prev;
    assign w_load_rise = w_load & ~r_load_prev;
    assign w_load_fall = ~w_load & r_load_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sck_sync  <= '0;
            r_sdi_sync  <= '0;
            r_load_sync <= '0;
            r_sck_prev  <= 1'b0;
            r_load_prev <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
            r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], load};
            r_sck_prev  <= w_sck;
            r_load_prev <= w_load;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_shadow    <= '0;
            xMatrix     <= '0;
            yMatrix     <= '0;
            frame_valid <= 1'b0;
            done        <= 1'b0;
            bit_err     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_load_rise) begin
                        r_state <= c_SHIFT;
                        r_cnt   <= '0;
                        bit_err <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                c_SHIFT: begin
                    // A bit arriving with the closing edge still counts.
                    if (w_sck_rise) begin
                        r_shadow <= {r_shadow[FRAME_BITS-2:0], w_sdi};
                        if (r_cnt != c_CNT_OVF) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    if (w_load_fall) begin
                        r_state <= c_CHECK;
                    end
                end
                c_CHECK: begin
                    if (r_cnt == c_CNT_FULL) begin
                        r_state <= c_COMMIT;
                    end else begin
                        r_state <= c_IDLE;
                        bit_err <= 1'b1;
                    end
                end
                c_COMMIT: begin
                    yMatrix     <= r_shadow[FRAME_BITS-1:c_HALF];
                    xMatrix     <= r_shadow[c_HALF-1:0];
                    frame_valid <= 1'b1;
                    done        <= 1'b1;
                    r_state     <= c_DONE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_frame_loader
// Brief    : Randomized self-checking bench for spi_frame_loader against a
//            frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_loader;

    localparam int FB = 144;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          sck;
    logic          sdi;
    logic          load;
    logic [FB/2-1:0] xm;
    logic [FB/2-1:0] ym;
    logic          fv;
    logic          done;
    logic          bit_err;

    int n_checks = 0;
    int n_errors = 0;

    bit              bits [160];
    logic [FB/2-1:0] exp_x;
    logic [FB/2-1:0] exp_y;
    logic            exp_fv;
    logic            exp_done;
    logic            exp_err;

    spi_frame_loader #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .reset       (reset),
        .sck         (sck),
        .sdi         (sdi),
        .load        (load),
        .xMatrix     (xm),
        .yMatrix     (ym),
        .frame_valid (fv),
        .done        (done),
        .bit_err     (bit_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_x"}, FB'(xm), FB'(exp_x));
        check({tag, "_y"}, FB'(ym), FB'(exp_y));
        check({tag, "_flags"}, FB'({fv, done, bit_err}), FB'({exp_fv, exp_done, exp_err}));
    endtask

    // Window outcome: exactly FB bits means the first FB bits form the frame,
    // first bit landing in the top bit of yMatrix; anything else keeps the old frame.
    task automatic model_window(input int nbits);
        logic [FB-1:0] f;
        if (nbits == FB) begin
            f = '0;
            for (int i = 0; i < FB; i++) f[FB-1-i] = bits[i];
            exp_y    = f[FB-1:FB/2];
            exp_x    = f[FB/2-1:0];
            exp_fv   = 1'b1;
            exp_done = 1'b1;
            exp_err  = 1'b0;
        end else begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
        end
    endtask

    task automatic send_bit(input bit b);
        sdi = b;
        repeat ($urandom_range(SS + 1, SS + 3)) @(negedge clk);
        sck = 1'b1;
        repeat ($urandom_range(SS + 1, SS + 3)) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic run_window(input string tag, input int nbits, input bit coinc);
        int lat;
        int exp_lat;
        @(negedge clk) load = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == nbits / 2) begin
                check({tag, "_hold_x"}, FB'(xm), FB'(exp_x));
                check({tag, "_hold_y"}, FB'(ym), FB'(exp_y));
            end
            if (coinc && i == nbits - 1) begin
                sdi = bits[i];
                repeat (SS + 2) @(negedge clk);
                sck  = 1'b1;
                load = 1'b0;
            end else begin
                send_bit(bits[i]);
            end
        end
        if (!coinc) begin
            repeat (4) @(negedge clk);
            load = 1'b0;
        end
        model_window(nbits);
        exp_lat = (nbits == FB) ? SS + 3 : SS + 2;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(done || bit_err) && lat < 40);
        check({tag, "_latency"}, FB'(lat), FB'(exp_lat));
        @(negedge clk) sck = 1'b0;
        repeat (6) @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) bits[i] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [7:0] pat;
        int         n;
        reset = 1'b0;
        sck   = 1'b0;
        sdi   = 1'b0;
        load  = 1'b0;
        exp_x = '0; exp_y = '0; exp_fv = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("reset");
        reset = 1'b1;

        // sck activity outside a load window must be ignored
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c % 4 == 0) begin
                sck = ~sck;
                sdi = 1'($urandom_range(0, 1));
            end
            if (c % 25 == 24) check_outputs("idle");
        end
        sck = 1'b0;

        pat = 8'hA5;
        for (int i = 0; i < FB; i++) bits[i] = pat[7 - (i % 8)];
        run_window("a5", FB, 1'b0);

        fill_random(FB - 1);
        run_window("short", FB - 1, 1'b0);
        fill_random(FB + 1);
        run_window("long", FB + 1, 1'b0);

        for (int i = 0; i < FB; i++) bits[i] = (i == 0);
        run_window("msb", FB, 1'b0);

        fill_random(FB);
        run_window("coinc", FB, 1'b1);

        // reset in the middle of a window discards everything
        @(negedge clk) load = 1'b1;
        repeat (4) @(negedge clk);
        fill_random(70);
        for (int i = 0; i < 70; i++) send_bit(bits[i]);
        reset = 1'b0;
        exp_x = '0; exp_y = '0; exp_fv = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("midrst");
        load = 1'b0;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_outputs("postrst");
        fill_random(FB);
        run_window("afterrst", FB, 1'b0);

        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    n = FB;
                2:       n = FB - 1 - $urandom_range(0, 10);
                default: n = FB + 1 + $urandom_range(0, 10);
            endcase
            fill_random(n);
            run_window("rand", n, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_frame_loader.md
# spi_frame_loader

Receives a 144-bit LED frame over the slow SPI link (sck/sdi/load) by oversampling on the fabric clock, then commits it atomically to the two 72-bit matrix registers consumed by the LED multiplexer core. It sits directly upstream of the scan/mux core and replaces the raw sck-clocked shift register, so the displayed frame never shows a partially shifted image. A frame is committed only if exactly FRAME_BITS bits were clocked in during the load window; otherwise the previous frame is kept and an error is flagged.

## Interface
- FRAME_BITS, 144: bits per frame; must be even; split equally between yMatrix (upper half) and xMatrix (lower half).
- SYNC_STAGES, 2: flip-flop stages in each input synchronizer; minimum 2.
- clk  in  1  fabric clock (HSOSC-derived).
- reset  in  1  asynchronous, active-low reset; all state is cleared while reset==0.
- sck  in  1  SPI clock from MCU, asynchronous to clk, idle low (CPOL=0, CPHA=0).
- sdi  in  1  SPI data, sampled on sck rising edge.
- load  in  1  frame window, active high; asynchronous to clk.
- xMatrix  out  FRAME_BITS/2  committed lower half of the frame.
- yMatrix  out  FRAME_BITS/2  committed upper half of the frame.
- frame_valid  out  1  high once any frame has been committed since reset; sticky.
- done  out  1  high in DONE state; last load window committed successfully.
- bit_err  out  1  last load window had a bit count other than FRAME_BITS; sticky until next load rise.

## Operation
- sck, sdi, load each pass through a SYNC_STAGES synchronizer (reset to 0); one further register per signal gives the previous value for edge detection.
- Shadow register {yS, xS} (FRAME_BITS wide) shifts MSB-first: on each synced sck rise while in SHIFT, {yS,xS} <= {yS,xS}[FRAME_BITS-2:0], sdi_sync. First bit sent ends in yMatrix MSB.
- Bit counter, width clog2(FRAME_BITS+2), cleared on entering SHIFT, increments per accepted bit, saturates at FRAME_BITS+1 (overflow marker).
- States:
  - IDLE: done=0. Synced load rise -> SHIFT (counter cleared, bit_err cleared).
  - SHIFT: accept bits. Synced load fall -> CHECK.
  - CHECK: counter==FRAME_BITS -> COMMIT; else -> IDLE with bit_err set.
  - COMMIT: xMatrix<=xS, yMatrix<=yS, frame_valid<=1; -> DONE.
  - DONE: done=1. Synced load rise -> SHIFT (done drops, counter and bit_err cleared).
- Shadow is not cleared between frames; only the count decides validity.
- Outputs xMatrix/yMatrix change only in COMMIT; never during SHIFT.

## Timing
- Reset values: xMatrix=0, yMatrix=0, frame_valid=0, done=0, bit_err=0, state IDLE, counter 0, shadow 0, sync/edge registers 0.
- Pin-to-synced latency: SYNC_STAGES clk cycles; edge acted upon one edge later.
- Synced load fall seen at edge N: CHECK at N+1, COMMIT at N+2, matrices/frame_valid/done updated at N+3.
- Simultaneous synced sck rise and load fall in the same cycle: the bit is accepted and counted; CHECK uses the incremented count.
- sck rise in IDLE, CHECK, COMMIT or DONE: ignored, counter unchanged.
- Load rise while in CHECK/COMMIT: ignored until DONE/IDLE is reached (load window shorter than 3 cycles is out of spec).
- More than FRAME_BITS bits: counter saturates at FRAME_BITS+1 -> error, no commit.
- sck high and low phases must each last at least SYNC_STAGES+1 clk periods; sdi stable across that sampling window. Faster sck is out of spec (undefined data, no lockup required beyond next load rise).
- Reset asserted mid-frame: immediate clear to reset values; the partial frame is discarded.

## Test plan
- Reset then idle: all outputs 0 for 100 cycles; toggling sck with load=0 changes nothing.
- Load high, shift 144 bits of pattern 0xA5 repeated, load low -> exactly 3 cycles after synced fall xMatrix=yMatrix=72'hA5A5…A5, done=1, frame_valid=1, bit_err=0.
- Load window with 143 bits, then 145 bits -> bit_err=1, done=0, xMatrix/yMatrix retain prior frame, state back to IDLE.
- Frame of first bit 1 followed by 143 zeros -> yMatrix=72'h800000000000000000, xMatrix=0; checks MSB-first ordering and half split.
- 144th sck rise coincident with load fall at synced level -> frame committed (count=144).
- Reset pulse after 70 bits, then full 144-bit frame -> outputs 0 during reset, new frame committed correctly afterwards, frame_valid=1.
